// File: rtl/morse_pkg.sv
// Shared definitions for the Morse letter path: FSM state encoding and symbol constants.
package morse_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SYM_ON,
      SYM_GAP,
      LTR_GAP
   } morse_state_e;

   localparam int unsigned MAX_LETTER_LEN = 4;
   localparam logic        SYM_DOT        = 1'b0;
   localparam logic        SYM_DASH       = 1'b1;

endpackage

// File: rtl/morse_unit_tick.sv
// Time-unit prescaler: one-cycle tick every TICK_CYCLES clocks, restarted by clr.
module morse_unit_tick #(
   parameter int unsigned TICK_CYCLES = 25_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [PW-1:0] LAST = PW'(TICK_CYCLES - 1);

   logic [PW-1:0] cnt_q, cnt_d;

   always_comb begin
      tick  = (cnt_q == LAST);
      cnt_d = cnt_q + PW'(1);
      if (clr || tick) cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/morse_symbol_sequencer.sv
// Plays one latched Morse letter on a single LED with a start/busy/done handshake.
module morse_symbol_sequencer
   import morse_pkg::*;
#(
   parameter int unsigned TICK_CYCLES      = 25_000_000,
   parameter int unsigned DOT_UNITS        = 1,
   parameter int unsigned DASH_UNITS       = 3,
   parameter int unsigned SYM_GAP_UNITS    = 1,
   parameter int unsigned LETTER_GAP_UNITS = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] letter_size,
   input  logic [3:0] letter_symbols,
   output logic       busy,
   output logic       done,
   output logic       led_out
);

   localparam logic [3:0] DOT_U  = 4'(DOT_UNITS);
   localparam logic [3:0] DASH_U = 4'(DASH_UNITS);
   localparam logic [3:0] SGAP_U = 4'(SYM_GAP_UNITS);
   localparam logic [3:0] LGAP_U = 4'(LETTER_GAP_UNITS);

   morse_state_e state_q, state_d;
   logic [3:0]   shreg_q, shreg_d;
   logic [2:0]   rem_q, rem_d;
   logic [3:0]   units_q, units_d;
   logic         led_q, led_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;
   logic         tick, clr, expire;
   logic [3:0]   dur;
   logic [3:0]   shamt;

   morse_unit_tick #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .tick  (tick)
   );

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      rem_d   = rem_q;
      units_d = units_q;
      done_d  = 1'b0;
      shamt   = 4'(MAX_LETTER_LEN) - letter_size;

      unique case (state_q)
         SYM_ON:  dur = (shreg_q[3] == SYM_DASH) ? DASH_U : DOT_U;
         SYM_GAP: dur = SGAP_U;
         LTR_GAP: dur = LGAP_U;
         default: dur = '0;
      endcase
      expire = tick && (units_q == dur - 4'd1);
      if (tick) units_d = units_q + 4'd1;

      unique case (state_q)
         IDLE: begin
            if (start && (letter_size != '0) && (letter_size <= 4'(MAX_LETTER_LEN))) begin
               shreg_d = letter_symbols << shamt;
               rem_d   = letter_size[2:0];
               state_d = SYM_ON;
            end
         end
         SYM_ON: begin
            if (expire) begin
               shreg_d = {shreg_q[2:0], 1'b0};
               rem_d   = rem_q - 3'd1;
               state_d = (rem_d != '0) ? SYM_GAP : LTR_GAP;
            end
         end
         SYM_GAP: if (expire) state_d = SYM_ON;
         LTR_GAP: begin
            if (expire) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Every transition is a state change, so entry restarts both unit counter and prescaler.
      clr = (state_d != state_q);
      if (clr) units_d = '0;

      led_d  = (state_d == SYM_ON);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         shreg_q <= '0;
         rem_q   <= '0;
         units_q <= '0;
         led_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         rem_q   <= rem_d;
         units_q <= units_d;
         led_q   <= led_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign led_out = led_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_morse_symbol_sequencer.sv
// Scoreboard bench: stimulus queues hand-computed per-cycle {led,busy,done}; a monitor pops and compares.
module tb_morse_symbol_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [3:0] letter_size;
   logic [3:0] letter_symbols;
   logic       busy, done, led_out;

   typedef struct packed {
      logic led;
      logic busy;
      logic done;
   } exp_t;

   exp_t expq[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   always #5 clk = ~clk;

   morse_symbol_sequencer #(.TICK_CYCLES(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .letter_size    (letter_size),
      .letter_symbols (letter_symbols),
      .busy           (busy),
      .done           (done),
      .led_out        (led_out)
   );

   task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cycle %0d: led/busy/done got %b expected %b", name, cyc, act, exp);
      end
   endtask

   // monitor: one queued expectation per clock edge, sampled 1 time unit after the edge
   always @(posedge clk) begin
      exp_t e;
      cyc++;
      #1;
      if (expq.size() > 0) begin
         e = expq.pop_front();
         check("wave", {led_out, busy, done}, e);
      end
   end

   task automatic seg(input logic l, input logic b, input logic d, input int n);
      exp_t e;
      e.led  = l;
      e.busy = b;
      e.done = d;
      for (int i = 0; i < n; i++) expq.push_back(e);
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(negedge clk);
         start = 1'b0;
      end
   endtask

   task automatic play_a();
      letter_size = 4'd2; letter_symbols = 4'b0001; start = 1'b1;
      seg(1, 1, 0, 4); seg(0, 1, 0, 4); seg(1, 1, 0, 12); seg(0, 1, 0, 12); seg(0, 0, 1, 1);
   endtask

   task automatic play_e();
      letter_size = 4'd1; letter_symbols = 4'b0000; start = 1'b1;
      seg(1, 1, 0, 4); seg(0, 1, 0, 12); seg(0, 0, 1, 1);
      cycles(17);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not complete, queue depth %0d expected 0", expq.size());
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; letter_size = '0; letter_symbols = '0;
      repeat (2) @(negedge clk);
      check("reset_state", {led_out, busy, done}, 3'b000);
      rst_n = 1'b1;
      seg(0, 0, 0, 3); cycles(3);

      // A: dot dash
      play_a(); cycles(33);
      seg(0, 0, 0, 2); cycles(2);

      // E: single dot
      play_e();
      seg(0, 0, 0, 2); cycles(2);

      // H: four dots
      letter_size = 4'd4; letter_symbols = 4'b0000; start = 1'b1;
      seg(1, 1, 0, 4);
      for (int i = 0; i < 3; i++) begin
         seg(0, 1, 0, 4); seg(1, 1, 0, 4);
      end
      seg(0, 1, 0, 12); seg(0, 0, 1, 1);
      cycles(41);
      seg(0, 0, 0, 2); cycles(2);

      // out-of-range sizes are ignored
      letter_size = 4'd0; letter_symbols = 4'hF; start = 1'b1;
      seg(0, 0, 0, 50); cycles(50);
      letter_size = 4'd5; letter_symbols = 4'hF; start = 1'b1;
      seg(0, 0, 0, 10); cycles(10);

      // A with a second start and changed letter inputs mid-playback
      play_a(); cycles(10);
      letter_size = 4'd1; letter_symbols = 4'b0001; start = 1'b1;
      cycles(23);
      seg(0, 0, 0, 2); cycles(2);

      // reset during A's dash
      play_a();
      expq.delete();
      seg(1, 1, 0, 4); seg(0, 1, 0, 4); seg(1, 1, 0, 3);
      cycles(11);
      rst_n = 1'b0;
      #1;
      check("async_reset", {led_out, busy, done}, 3'b000);
      seg(0, 0, 0, 2); cycles(2);
      rst_n = 1'b1;
      seg(0, 0, 0, 3); cycles(3);

      // G: dash dash dot
      letter_size = 4'd3; letter_symbols = 4'b0110; start = 1'b1;
      seg(1, 1, 0, 12); seg(0, 1, 0, 4); seg(1, 1, 0, 12); seg(0, 1, 0, 4);
      seg(1, 1, 0, 4); seg(0, 1, 0, 12); seg(0, 0, 1, 1);
      cycles(49);
      seg(0, 0, 0, 2); cycles(2);

      // back-to-back E: second start held during the done cycle
      play_e();
      play_e();
      seg(0, 0, 0, 3); cycles(3);

      tests++;
      if (expq.size() != 0) begin
         fails++;
         $display("FAIL queue_drain: %0d entries left, expected 0", expq.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
